exu_ctrl: RTL and testbench

- Sequencing controller that turns the combinational execute datapath (ALU + branch/jump unit) into a handshaked pipeline stage between IDU and LSU.
- Latches one decoded request and presents it to the execute datapath for 1 cycle, or LAT cycles for multi-cycle ops.
- Captures res/npc/cnd, holds them until LSU accepts, and raises a one-cycle redirect to IFU on a taken branch or jump.
- Supports flush from the commit/trap path.

---
 rtl/exu_ctrl_pkg.sv | 17 +
 rtl/exu_lat_cnt.sv | 29 ++
 rtl/exu_ctrl.sv | 131 +++++++++++++
 tb/tb_exu_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/exu_ctrl_pkg.sv
// Shared definitions for the execute-stage sequencing controller.
// State encoding, default widths and the sequential PC step.
package exu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } exu_state_e;

  localparam int XLEN_D      = 32;
  localparam int PAYLOAD_W_D = 192;
  localparam int LAT_D       = 4;
  localparam int PC_INC      = 4;

endpackage

// File: rtl/exu_lat_cnt.sv
// Loadable 4-bit down-counter with zero flag.
// Sequences the extra cycles of multi-cycle execute ops.
module exu_lat_cnt (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= 4'd0;
    end else if (clr_i) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/exu_ctrl.sv
// Execute-stage controller: handshaked wrapper around the
// combinational ALU/branch datapath between IDU and LSU.
module exu_ctrl
  import exu_ctrl_pkg::*;
#(
  parameter int XLEN      = XLEN_D,
  parameter int PAYLOAD_W = PAYLOAD_W_D,
  parameter int LAT       = LAT_D
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [XLEN-1:0]      in_pc_i,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  input  logic                 in_multi_i,
  input  logic                 in_ctrl_flow_i,
  output logic [PAYLOAD_W-1:0] exu_payload_o,
  output logic [XLEN-1:0]      exu_pc_o,
  input  logic [XLEN-1:0]      exu_res_i,
  input  logic [XLEN-1:0]      exu_npc_i,
  input  logic                 exu_cnd_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      out_pc_o,
  output logic [XLEN-1:0]      out_res_o,
  output logic [XLEN-1:0]      out_npc_o,
  output logic                 redirect_valid_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  input  logic                 flush_i,
  output logic                 busy_o
);

  localparam logic [3:0] LAT_LD = 4'(LAT - 2);

  exu_state_e           state_q;
  logic [XLEN-1:0]      pc_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 multi_q;
  logic                 cf_q;
  logic [XLEN-1:0]      res_q;
  logic [XLEN-1:0]      npc_q;
  logic                 cnd_q;
  logic                 redir_q;

  logic fire;
  logic cap;
  logic cnt_zero;
  logic cnt_load;
  logic cnt_dec;

  assign in_ready_o = rst_n_i & ~flush_i &
    ((state_q == S_IDLE) |
     ((state_q == S_OUT) & out_ready_i));

  assign fire = in_valid_i & in_ready_o;

  assign cap =
    ((state_q == S_EXEC) & ~multi_q) |
    ((state_q == S_WAIT) & cnt_zero);

  assign cnt_load = ~flush_i & (state_q == S_EXEC) & multi_q;
  assign cnt_dec  = ~flush_i & (state_q == S_WAIT);

  exu_lat_cnt u_lat_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (flush_i),
    .load_i     (cnt_load),
    .load_val_i (LAT_LD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      payload_q <= '0;
      multi_q   <= 1'b0;
      cf_q      <= 1'b0;
      res_q     <= '0;
      npc_q     <= '0;
      cnd_q     <= 1'b0;
      redir_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      redir_q <= 1'b0;
    end else begin
      redir_q <= 1'b0;
      if (cap) begin
        res_q   <= exu_res_i;
        npc_q   <= exu_npc_i;
        cnd_q   <= exu_cnd_i;
        redir_q <= cf_q &
          (exu_npc_i != pc_q + XLEN'(PC_INC));
      end
      if (fire) begin
        pc_q      <= in_pc_i;
        payload_q <= in_payload_i;
        multi_q   <= in_multi_i;
        cf_q      <= in_ctrl_flow_i;
      end
      unique case (state_q)
        S_IDLE: if (fire) state_q <= S_EXEC;
        S_EXEC: state_q <= multi_q ? S_WAIT : S_OUT;
        S_WAIT: if (cnt_zero) state_q <= S_OUT;
        S_OUT: begin
          if (fire)             state_q <= S_EXEC;
          else if (out_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Taken/not-taken is already folded into npc; cnd is kept for debug.
  logic unused_cnd;
  assign unused_cnd = cnd_q;

  assign exu_payload_o    = payload_q;
  assign exu_pc_o         = pc_q;
  assign out_valid_o      = (state_q == S_OUT) & ~flush_i;
  assign out_pc_o         = pc_q;
  assign out_res_o        = res_q;
  assign out_npc_o        = npc_q;
  assign redirect_valid_o = redir_q & ~flush_i;
  assign redirect_pc_o    = npc_q;
  assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_exu_ctrl.sv
// Randomized bench for exu_ctrl against a transaction-level model.
// Inputs change on negedge; outputs are checked 1 ns later.
module tb_exu_ctrl;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_pc;
  logic [191:0] in_payload;
  logic         in_multi;
  logic         in_cf;
  logic [191:0] exu_payload;
  logic [31:0]  exu_pc;
  logic [31:0]  exu_res;
  logic [31:0]  exu_npc;
  logic         exu_cnd;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_pc;
  logic [31:0]  out_res;
  logic [31:0]  out_npc;
  logic         redir_valid;
  logic [31:0]  redir_pc;
  logic         flush;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  exu_ctrl #(.XLEN(32), .PAYLOAD_W(192), .LAT(LAT)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_pc_i          (in_pc),
    .in_payload_i     (in_payload),
    .in_multi_i       (in_multi),
    .in_ctrl_flow_i   (in_cf),
    .exu_payload_o    (exu_payload),
    .exu_pc_o         (exu_pc),
    .exu_res_i        (exu_res),
    .exu_npc_i        (exu_npc),
    .exu_cnd_i        (exu_cnd),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_pc_o         (out_pc),
    .out_res_o        (out_res),
    .out_npc_o        (out_npc),
    .redirect_valid_o (redir_valid),
    .redirect_pc_o    (redir_pc),
    .flush_i          (flush),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  // model: busy, result held, cycles of execution left
  bit           m_busy, m_out, m_first;
  int           m_left;
  logic [31:0]  t_pc, t_res, t_npc;
  logic [191:0] t_pay;
  bit           t_cf;
  logic [31:0]  c_pc, c_res, c_npc;

  task automatic check(input string tag,
                       input logic [191:0] got,
                       input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_out = 0; m_first = 0; m_left = 0;
    t_pc = '0; t_res = '0; t_npc = '0; t_pay = '0; t_cf = 0;
    c_pc = '0; c_res = '0; c_npc = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"}, in_ready, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".redir"}, redir_valid, 0);
    check({tag, ".out_res"}, out_res, 0);
    check({tag, ".out_npc"}, out_npc, 0);
    check({tag, ".out_pc"}, out_pc, 0);
    check({tag, ".exu_pc"}, exu_pc, 0);
    check({tag, ".exu_pay"}, exu_payload, 0);
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic cycle(input bit v, input logic [31:0] pc,
                       input bit multi, input bit cf,
                       input logic [31:0] res,
                       input logic [31:0] npc,
                       input bit ordy, input bit fl);
    bit exp_rdy, fire, done;
    in_valid   = v;
    in_pc      = pc;
    in_payload = {$urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom};
    in_multi   = multi;
    in_cf      = cf;
    out_ready  = ordy;
    flush      = fl;
    exu_cnd    = 1'($urandom);
    done = m_busy && !m_out && m_left == 1;
    // datapath answer is only right on the final execute cycle
    exu_res = done ? t_res : ~t_res;
    exu_npc = done ? t_npc : ~t_npc;
    #1;
    exp_rdy = !fl && (!m_busy || (m_out && ordy));
    check("in_ready", in_ready, exp_rdy);
    check("busy", busy, m_busy);
    check("out_valid", out_valid, m_out && !fl);
    check("redir_valid", redir_valid, m_first && !fl);
    if (m_out) begin
      check("out_pc", out_pc, c_pc);
      check("out_res", out_res, c_res);
      check("out_npc", out_npc, c_npc);
    end
    if (m_first) check("redir_pc", redir_pc, c_npc);
    if (m_busy) begin
      check("exu_pc", exu_pc, t_pc);
      check("exu_pay", exu_payload, t_pay);
    end
    fire = v && exp_rdy;
    if (fl) begin
      m_busy = 0; m_out = 0; m_first = 0;
    end else begin
      m_first = 0;
      if (m_busy && !m_out) begin
        m_left--;
        if (m_left == 0) begin
          m_out = 1;
          c_pc = t_pc; c_res = t_res; c_npc = t_npc;
          m_first = t_cf && (t_npc != t_pc + 32'd4);
        end
      end else if (m_out && ordy) begin
        m_out = 0; m_busy = 0;
      end
      if (fire) begin
        t_pc = pc; t_pay = in_payload; t_cf = cf;
        t_res = res; t_npc = npc;
        m_busy = 1; m_out = 0;
        m_left = multi ? LAT : 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++)
      cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, ordy, 0);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_pc = 0; in_payload = 0;
    in_multi = 0; in_cf = 0; exu_res = 0; exu_npc = 0;
    exu_cnd = 0; out_ready = 0; flush = 0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1;

    // single op
    cycle(1, 32'h8000_0000, 0, 0, 32'h1234, 32'h8000_0004, 1, 0);
    idle(3, 1);
    // multi op
    cycle(1, 32'h8000_0100, 1, 0, 32'hDEAD, 32'h8000_0104, 1, 0);
    idle(6, 1);
    // taken branch, LSU stalls 3 cycles
    cycle(1, 32'h8000_0010, 0, 1, 32'h0, 32'h8000_0040, 0, 0);
    idle(4, 0);
    idle(2, 1);
    // not-taken branch; jal wrapping to 0
    cycle(1, 32'h8000_0010, 0, 1, 32'h0, 32'h8000_0014, 1, 0);
    idle(3, 1);
    cycle(1, 32'hFFFF_FFFC, 0, 1, 32'h0, 32'h0, 1, 0);
    idle(3, 1);
    // back-to-back
    cycle(1, 32'h8000_0200, 0, 0, 32'h11, 32'h8000_0204, 1, 0);
    cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
    cycle(1, 32'h8000_0204, 0, 0, 32'h22, 32'h8000_0208, 1, 0);
    idle(3, 1);
    // flush during WAIT with a request pending
    cycle(1, 32'h8000_0300, 1, 0, 32'hBEEF, 32'h8000_0304, 1, 0);
    cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
    cycle(1, 32'h8000_0400, 0, 0, 32'h5, 32'h8000_0404, 1, 1);
    idle(6, 1);
    // async reset mid-WAIT
    cycle(1, 32'h8000_0500, 1, 1, 32'h77, 32'h8000_0600, 1, 0);
    idle(2, 1);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc, npc;
      pc = ($urandom % 8 == 0) ? 32'hFFFF_FFFC
                               : {$urandom, 2'b00} >> 0;
      pc[1:0] = 2'b00;
      npc = ($urandom % 2) ? pc + 32'd4 : {$urandom};
      cycle(1'($urandom % 2), pc, $urandom % 3 == 0,
            1'($urandom), $urandom, npc,
            $urandom % 4 != 0, $urandom % 40 == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
